// File: rtl/bcd_scan_display.sv
// Three-digit multiplexed 7-segment driver for a BCD value (hundreds 0-3).
// New values are staged through a one-deep pending register and applied only at frame boundaries.

module bcd_seg_dec (
  input  logic [3:0] val,
  input  logic       blank,
  output logic [6:0] seg
);
  // Active-low {g,f,e,d,c,b,a}; codes above 9 show a dash
  always_comb begin
    seg = 7'h3F;
    if (blank) seg = 7'h7F;
    else begin
      case (val)
        4'd0: seg = 7'h40;
        4'd1: seg = 7'h79;
        4'd2: seg = 7'h24;
        4'd3: seg = 7'h30;
        4'd4: seg = 7'h19;
        4'd5: seg = 7'h12;
        4'd6: seg = 7'h02;
        4'd7: seg = 7'h78;
        4'd8: seg = 7'h00;
        4'd9: seg = 7'h10;
        default: seg = 7'h3F;
      endcase
    end
  end
endmodule

module bcd_scan_display #(
  parameter int DIV      = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef struct packed {
    logic [1:0] h;
    logic [3:0] t;
    logic [3:0] o;
  } bcd_t;

  logic [PW-1:0]     presc;
  logic [1:0]        idx;
  logic              tick, frame_end;
  logic              pend_full;
  bcd_t              pend, disp;
  logic [2:0][3:0]   dig;
  logic [2:0]        blk;
  logic [2:0][6:0]   dseg;
  logic [2:0]        nxt_an;
  logic [6:0]        nxt_seg;

  assign tick      = (presc == PW'(DIV - 1));
  assign frame_end = tick && (idx == 2'd2);
  assign in_ready  = ~pend_full;

  assign dig = {{2'b00, disp.h}, disp.t, disp.o};
  assign blk[0] = 1'b0;
  assign blk[1] = (LZ_BLANK != 0) && (disp.h == 2'd0) && (disp.t == 4'd0);
  assign blk[2] = (LZ_BLANK != 0) && (disp.h == 2'd0);

  for (genvar g = 0; g < 3; g++) begin : g_dec
    bcd_seg_dec u_dec (.val(dig[g]), .blank(blk[g]), .seg(dseg[g]));
  end

  always_comb begin
    nxt_an  = 3'b110;
    nxt_seg = dseg[0];
    case (idx)
      2'd1: begin nxt_an = 3'b101; nxt_seg = dseg[1]; end
      2'd2: begin nxt_an = 3'b011; nxt_seg = dseg[2]; end
      default: begin nxt_an = 3'b110; nxt_seg = dseg[0]; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= 2'd0;
      pend_full  <= 1'b0;
      pend       <= '0;
      disp       <= '0;
      an         <= 3'b111;
      seg        <= 7'h7F;
      frame_tick <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      frame_tick <= frame_end;
      // A transfer only lands while empty, so it can never be committed in the same frame-end edge
      if (frame_end && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end else if (in_valid && !pend_full) begin
        pend      <= '{h: bcd2, t: bcd1, o: bcd0};
        pend_full <= 1'b1;
      end
      an  <= nxt_an;
      seg <= nxt_seg;
    end
  end
endmodule

// File: tb/tb_bcd_scan_display.sv
// Random plus directed stimulus against a cycle-count reference model of the scan display.
// Two instances share inputs: one with leading-zero blanking, one without.

module tb_bcd_scan_display;
  localparam int DIV = 4;
  localparam int FRM = 3 * DIV;

  logic       clk, rst_n, in_valid;
  logic [1:0] bcd2;
  logic [3:0] bcd1, bcd0;
  logic       rdy_a, rdy_b, ft_a, ft_b;
  logic [2:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;

  bcd_scan_display #(.DIV(DIV), .LZ_BLANK(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .in_valid(in_valid), .in_ready(rdy_a), .an(an_a), .seg(seg_a), .frame_tick(ft_a));

  bcd_scan_display #(.DIV(DIV), .LZ_BLANK(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .in_valid(in_valid), .in_ready(rdy_b), .an(an_b), .seg(seg_b), .frame_tick(ft_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int k = 0;          // clock edges since reset release
  bit pf = 1'b0;
  bit [9:0] pend = '0, disp = '0;
  logic [6:0] tbl [0:9];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  function automatic logic [6:0] segx(input bit [9:0] v, input int d, input bit lz);
    int h, t, o, x;
    h = int'(v[9:8]); t = int'(v[7:4]); o = int'(v[3:0]);
    if (lz && d == 2 && h == 0) return 7'h7F;
    if (lz && d == 1 && h == 0 && t == 0) return 7'h7F;
    x = (d == 0) ? o : (d == 1) ? t : h;
    return (x > 9) ? 7'h3F : tbl[x];
  endfunction

  task automatic cyc(input bit r, input bit v, input bit [9:0] val);
    bit fe;
    int d;
    logic [2:0] ea;
    rst_n = r; in_valid = v; {bcd2, bcd1, bcd0} = val;
    @(posedge clk); #1;
    if (!r) begin
      k = 0; pf = 1'b0; pend = '0; disp = '0;
      chk("rst_an_a", an_a, 3'b111);   chk("rst_seg_a", seg_a, 7'h7F);
      chk("rst_an_b", an_b, 3'b111);   chk("rst_seg_b", seg_b, 7'h7F);
      chk("rst_ft", {ft_a, ft_b}, 2'b00);
      chk("rst_rdy", {rdy_a, rdy_b}, 2'b11);
    end else begin
      k++;
      fe = (k % FRM == 0);
      d  = ((k - 1) / DIV) % 3;
      ea = 3'b111 & ~(3'b001 << d);
      chk("an_a", an_a, ea);
      chk("an_b", an_b, ea);
      chk("seg_a", seg_a, segx(disp, d, 1'b1));
      chk("seg_b", seg_b, segx(disp, d, 1'b0));
      chk("ftick", {ft_a, ft_b}, {fe, fe});
      if (fe && pf) begin disp = pend; pf = 1'b0; end
      else if (v && !pf) begin pend = val; pf = 1'b1; end
      chk("ready", {rdy_a, rdy_b}, {!pf, !pf});
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 10'h0);
  endtask

  initial begin
    bit hit, was;
    tbl[0] = 7'h40; tbl[1] = 7'h79; tbl[2] = 7'h24; tbl[3] = 7'h30; tbl[4] = 7'h19;
    tbl[5] = 7'h12; tbl[6] = 7'h02; tbl[7] = 7'h78; tbl[8] = 7'h00; tbl[9] = 7'h10;
    rst_n = 1'b0; in_valid = 1'b0; {bcd2, bcd1, bcd0} = '0;

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 10'h0);
    cyc(1'b1, 1'b1, {2'd2, 4'd5, 4'd5});   // 255 on the first cycle
    idle(30);
    cyc(1'b1, 1'b1, {2'd0, 4'd0, 4'd7});
    idle(30);
    // back-to-back: 0/4/2 held while busy must wait for the commit
    cyc(1'b1, 1'b1, {2'd1, 4'd2, 4'd8});
    for (int i = 0; i < 60; i++) begin
      was = pf;
      cyc(1'b1, 1'b1, {2'd0, 4'd4, 4'd2});
      if (!was) break;
    end
    idle(30);
    // transfer landing exactly on a frame-end edge
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!pf && ((k + 1) % FRM == 0)) begin hit = 1'b1; break; end
      idle(1);
    end
    chk("fe_align", hit, 1'b1);
    cyc(1'b1, 1'b1, {2'd3, 4'd9, 4'd1});
    idle(30);
    // reset with a value pending
    idle(5);
    cyc(1'b1, 1'b1, {2'd1, 4'd1, 4'd1});
    idle(2);
    cyc(1'b0, 1'b0, 10'h0);
    cyc(1'b0, 1'b0, 10'h0);
    idle(30);

    for (int i = 0; i < 800; i++) begin
      bit r, v;
      bit [9:0] val;
      r   = ($urandom_range(0, 199) != 0);
      v   = ($urandom_range(0, 3) == 0);
      val = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 1) == 1) val[7:4] = 4'd0;
      if ($urandom_range(0, 1) == 1) val[9:8] = 2'd0;
      cyc(r, v, val);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
